freq_ratio_pwm: RTL

//  Multi-channel gated frequency counter plus programmable PWM set/reset generator for the

---
 rtl/freq_ratio_pwm_if.sv | 55 +++++
 rtl/freq_ratio_pwm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_ratio_pwm_if.sv
// freq_ratio_pwm_if
//   Bundles everything that crosses the freq_ratio_pwm boundary except the core
//   clock and reset.
//   Ports carried:
//     en          global enable (controller -> block)
//     clk_in      NCH external clocks to measure, asynchronous to the core clock
//     pwm_w       PWM high time in core cycles, sampled at each period start
//     val         latched per-channel edge counts, channel k at [k*CNT_W +: CNT_W]
//     ovf         per-channel saturation flag for the last closed window
//     val_valid   one-cycle strobe when val/ovf are refreshed
//     pwm_set     one-cycle pulse at the start of the PWM high phase
//     pwm_reset   one-cycle pulse at the end of the PWM high phase
//     pwm_signal  PWM level
//   Modports:
//     master  controller / testbench side (drives en, clk_in, pwm_w)
//     slave   freq_ratio_pwm side (drives the results)
interface freq_ratio_pwm_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 7,
  parameter int W_W   = 13
);
  logic                 en;
  logic [NCH-1:0]       clk_in;
  logic [W_W-1:0]       pwm_w;
  logic [NCH*CNT_W-1:0] val;
  logic [NCH-1:0]       ovf;
  logic                 val_valid;
  logic                 pwm_set;
  logic                 pwm_reset;
  logic                 pwm_signal;

  modport master (
    output en,
    output clk_in,
    output pwm_w,
    input  val,
    input  ovf,
    input  val_valid,
    input  pwm_set,
    input  pwm_reset,
    input  pwm_signal
  );

  modport slave (
    input  en,
    input  clk_in,
    input  pwm_w,
    output val,
    output ovf,
    output val_valid,
    output pwm_set,
    output pwm_reset,
    output pwm_signal
  );
endinterface

// File: rtl/freq_ratio_pwm.sv
// freq_ratio_pwm
//   Multi-channel gated frequency counter plus PWM set/reset generator for the
//   photonic-switch driver.
//   - Each of the NCH external clocks is brought into the core domain through a
//     two-flop synchroniser plus a third flop for rising-edge detection.
//   - A gate counter defines a window of GATE_CYCLES enabled core cycles. Edges
//     seen inside the window are counted (saturating at 2**CNT_W-1); at the last
//     cycle of the window the counts are published on val/ovf and val_valid
//     strobes for one cycle.
//   - An independent PWM counter of PWM_PERIOD enabled cycles latches pwm_w at
//     the period start and produces set/reset pulses plus the PWM level.
//   Ports:
//     clk    core clock
//     reset  asynchronous reset, active low
//     bus    freq_ratio_pwm_if slave modport (en, clk_in, pwm_w in;
//            val, ovf, val_valid, pwm_set, pwm_reset, pwm_signal out)
//   Every output comes straight from a flop; there is no combinational path
//   from any input to any output.
module freq_ratio_pwm #(
  parameter int NCH         = 2,
  parameter int CNT_W       = 7,
  parameter int GATE_CYCLES = 200,
  parameter int W_W         = 13,
  parameter int PWM_PERIOD  = 8000
) (
  input  logic            clk,
  input  logic            reset,
  freq_ratio_pwm_if.slave bus
);

  localparam int G_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int P_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  localparam logic [G_W-1:0]   G_LAST   = G_W'(GATE_CYCLES - 1);
  localparam logic [P_W-1:0]   P_LAST   = P_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [31:0]      PERIOD_U = 32'(PWM_PERIOD);

  // Input synchroniser and edge detect
  logic [NCH-1:0]       sync1_q, sync1_d;
  logic [NCH-1:0]       sync2_q, sync2_d;
  logic [NCH-1:0]       sync3_q, sync3_d;
  logic [NCH-1:0]       edge_det;

  // Gate window and per-channel counting
  logic [G_W-1:0]       g_q, g_d;
  logic [CNT_W-1:0]     cnt_q   [NCH];
  logic [CNT_W-1:0]     cnt_d   [NCH];
  logic [CNT_W-1:0]     cnt_inc [NCH];
  logic [NCH-1:0]       add_ovf;
  logic [NCH-1:0]       sat_q, sat_d;

  // Published results
  logic [NCH*CNT_W-1:0] val_q, val_d;
  logic [NCH-1:0]       ovf_q, ovf_d;
  logic                 val_valid_q, val_valid_d;

  // PWM engine
  logic [P_W-1:0]       p_q, p_d;
  logic [W_W-1:0]       w_lat_q, w_lat_d;
  logic                 pwm_set_q, pwm_set_d;
  logic                 pwm_reset_q, pwm_reset_d;
  logic                 pwm_signal_q, pwm_signal_d;
  logic                 high_end;

  // The synchroniser chain runs every cycle, independent of en, so that
  // re-enabling never sees a stale edge from before the pause.
  always_comb begin
    sync1_d = bus.clk_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  assign edge_det = sync2_q & ~sync3_q;

  // Saturating add of this cycle's edge onto the running count. add_ovf marks an
  // edge that arrived while the counter was already pinned at its maximum,
  // i.e. an edge that could not be represented.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_inc[k] = cnt_q[k];
    end
    add_ovf = '0;
    for (int k = 0; k < NCH; k++) begin
      if (edge_det[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          add_ovf[k] = 1'b1;
        end else begin
          cnt_inc[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Gate window. On the closing cycle the edge of that very cycle is folded
  // into the published value and the running counter restarts from zero, so a
  // boundary edge lands in exactly one window. With en low everything holds and
  // edges are dropped.
  always_comb begin
    g_d         = g_q;
    sat_d       = sat_q;
    val_d       = val_q;
    ovf_d       = ovf_q;
    val_valid_d = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = cnt_q[k];
    end

    if (bus.en) begin
      if (g_q == G_LAST) begin
        g_d         = '0;
        sat_d       = '0;
        val_valid_d = 1'b1;
        for (int k = 0; k < NCH; k++) begin
          val_d[k*CNT_W +: CNT_W] = cnt_inc[k];
          ovf_d[k]                = sat_q[k] | add_ovf[k];
          cnt_d[k]                = '0;
        end
      end else begin
        g_d   = g_q + 1'b1;
        sat_d = sat_q | add_ovf;
        for (int k = 0; k < NCH; k++) begin
          cnt_d[k] = cnt_inc[k];
        end
      end
    end
  end

  // End of the high phase: only meaningful for a non-zero duty that fits inside
  // the period. At p==0 this can never fire because w_lat must be non-zero.
  always_comb begin
    high_end = (w_lat_q != '0) && (32'(w_lat_q) < PERIOD_U) &&
               (32'(p_q) == 32'(w_lat_q));
  end

  // PWM engine. The duty word is captured only at the period start so that a
  // mid-period change of pwm_w affects the next period. A zero duty word forces
  // the level low for the whole period; a duty word at or above the period
  // keeps the level high and re-issues the set pulse every period.
  always_comb begin
    p_d          = p_q;
    w_lat_d      = w_lat_q;
    pwm_set_d    = 1'b0;
    pwm_reset_d  = 1'b0;
    pwm_signal_d = pwm_signal_q;

    if (bus.en) begin
      p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
      if (p_q == '0) begin
        w_lat_d      = bus.pwm_w;
        pwm_set_d    = (bus.pwm_w != '0);
        pwm_signal_d = (bus.pwm_w != '0);
      end else if (high_end) begin
        pwm_reset_d  = 1'b1;
        pwm_signal_d = 1'b0;
      end
    end
  end

  // All state, including the synchroniser flops, clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync3_q      <= '0;
      g_q          <= '0;
      sat_q        <= '0;
      val_q        <= '0;
      ovf_q        <= '0;
      val_valid_q  <= 1'b0;
      p_q          <= '0;
      w_lat_q      <= '0;
      pwm_set_q    <= 1'b0;
      pwm_reset_q  <= 1'b0;
      pwm_signal_q <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      g_q          <= g_d;
      sat_q        <= sat_d;
      val_q        <= val_d;
      ovf_q        <= ovf_d;
      val_valid_q  <= val_valid_d;
      p_q          <= p_d;
      w_lat_q      <= w_lat_d;
      pwm_set_q    <= pwm_set_d;
      pwm_reset_q  <= pwm_reset_d;
      pwm_signal_q <= pwm_signal_d;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.val        = val_q;
  assign bus.ovf        = ovf_q;
  assign bus.val_valid  = val_valid_q;
  assign bus.pwm_set    = pwm_set_q;
  assign bus.pwm_reset  = pwm_reset_q;
  assign bus.pwm_signal = pwm_signal_q;

endmodule
